print_in_conditioner: RTL and testbench
=======================================

// Module: print_in_conditioner
// PURPOSE
//  Conditions the raw "Print" request input from the autoclave front panel before it
//  reaches the HPS-visible Print_in PIO (1-bit in_port, read over Avalon-MM).
//  Performs metastability synchronisation, counter-based debounce and edge detection.
//  Keeps press/glitch statistics so firmware and bench can qualify the switch.
//  Sits directly upstream of the PIO: level_out drives its in_port.
// PARAMETERS
//  SYNC_STAGES      2      synchroniser flop count (legal: >=2)
//  DEBOUNCE_CYCLES  50000  consecutive stable cycles required (1 ms @ 50 MHz; legal: >=2)
//  DB_W             16     debounce counter width (2**DB_W > DEBOUNCE_CYCLES)
//  CNT_W            8      width of press_count / glitch_count
//  INVERT           0      1 = raw_in is active-low; inverted before the synchroniser
// PORTS
//  clk           in   1      system clock
//  reset_n       in   1      reset
//  raw_in        in   1      asynchronous panel signal
//  clr_counts    in   1      synchronous clear of press_count and glitch_count
//  level_out     out  1      debounced level; drives PIO in_port
//  rise_pulse    out  1      1-cycle strobe on debounced 0->1
//  fall_pulse    out  1      1-cycle strobe on debounced 1->0
//  press_count   out  CNT_W  debounced rising edges; wraps modulo 2**CNT_W
//  glitch_count  out  CNT_W  aborted debounce attempts; saturates at all-ones
// BEHAVIOUR
//  - One clock, clk. Reset is synchronous, active-low, on reset_n.
//  - Reset: sync chain=0, state=STABLE_LO, debounce counter=0.
//    level_out, rise_pulse, fall_pulse, press_count and glitch_count all =0.
//  - s = last synchroniser stage; raw_in ^ INVERT enters stage 0. No other path from raw_in.
//  - FSM states: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO.
//    STABLE_LO: s=1 -> CHK_HI, counter<=0; otherwise stay.
//    CHK_HI:    s=0 -> STABLE_LO, glitch_count++.
//               s=1 and counter==DEBOUNCE_CYCLES-1 -> STABLE_HI.
//               otherwise counter++.
//    STABLE_HI, CHK_LO: mirror images of the above (target s=0, abort -> STABLE_HI).
//  - level_out is a register: 1 exactly when state is STABLE_HI or CHK_LO.
//  - rise_pulse is registered and asserts in the same cycle level_out first reads 1.
//    fall_pulse likewise for level_out first reading 0. Each is high for exactly 1 cycle.
//  - Latency: first clock edge sampling raw_in=1 to level_out=1 is
//    SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles. Falling edge has the same latency.
//  - Glitch: a level shorter than DEBOUNCE_CYCLES+1 synchronised cycles never changes
//    level_out. It increments glitch_count once per abort.
//  - Counters:
//    press_count increments on every rise_pulse.
//    glitch_count saturates; no wrap.
//    clr_counts has priority: clear and increment in the same cycle -> result 0.
//  - Reset mid-debounce: abort discards progress; no pulse, no count.
//    If raw_in is already active after release, a full debounce runs and rise_pulse fires
//    normally.
//  - Debounce counter never exceeds DEBOUNCE_CYCLES-1; it is only live in CHK states.
// TESTING (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, INVERT=0, CNT_W=8)
//  1 Reset: hold reset_n=0 with raw_in=1 for 3 cycles -> all outputs 0.
//    Release -> level_out=1 on cycle 7 after release, rise_pulse=1 for 1 cycle,
//    press_count=1.
//  2 Clean press: raw_in 0->1, held 20 cycles, then 1->0 -> level_out high from cycle 7
//    to cycle 27; one rise_pulse and one fall_pulse; press_count +1; glitch_count
//    unchanged.
//  3 Glitch: raw_in high for 3 cycles, then low -> level_out stays 0, no pulses,
//    glitch_count=1. Same on a 2-cycle low dip while STABLE_HI -> level_out stays 1,
//    glitch_count=2.
//  4 Wrap/saturate: 256 clean presses -> press_count=0.
//    Force 260 glitches -> glitch_count=255.
//  5 Simultaneous: assert clr_counts in the exact cycle rise_pulse=1 -> press_count=0
//    the next cycle.
//  6 INVERT=1: raw_in held 0 for 10 cycles -> level_out=1 at cycle 7; raw_in=1 ->
//    level_out returns to 0 after 7 cycles.

Source files
------------

// File: rtl/print_in_conditioner.sv
// -----------------------------------------------------------------------------
// print_in_conditioner
//
// Conditions the raw front-panel "Print" request before it reaches the
// HPS-visible Print_in PIO. The raw signal is optionally inverted,
// synchronised into the clk domain, debounced by a four-state
// counter-qualified FSM and edge-detected. Press and glitch statistics are
// kept so firmware can qualify the switch.
//
// Ports
//   clk           in   1      system clock
//   reset_n       in   1      synchronous active-low reset
//   raw_in        in   1      asynchronous panel signal
//   clr_counts    in   1      synchronous clear of press_count / glitch_count
//   level_out     out  1      debounced level, drives the PIO in_port
//   rise_pulse    out  1      one-cycle strobe on debounced 0->1
//   fall_pulse    out  1      one-cycle strobe on debounced 1->0
//   press_count   out  CNT_W  debounced rising edges, wraps
//   glitch_count  out  CNT_W  aborted debounce attempts, saturates
//
// Parameters
//   SYNC_STAGES      synchroniser depth (>= 2)
//   DEBOUNCE_CYCLES  consecutive stable cycles required (>= 2)
//   DB_W             debounce counter width (2**DB_W > DEBOUNCE_CYCLES)
//   CNT_W            statistics counter width
//   INVERT           1 = raw_in is active-low
// -----------------------------------------------------------------------------
module print_in_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DB_W            = 16,
  parameter int CNT_W           = 8,
  parameter bit INVERT          = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             raw_in,
  input  logic             clr_counts,
  output logic             level_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] press_count,
  output logic [CNT_W-1:0] glitch_count
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } state_t;

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state;
  state_t                 next_state;
  logic [DB_W-1:0]        db_cnt;
  logic [DB_W-1:0]        db_cnt_d;
  logic                   level_d;
  logic                   abort;

  // ---------------------------------------------------------------------------
  // Synchroniser. Polarity is fixed before the first flop so that the whole
  // downstream logic only ever deals with an active-high request.
  // ---------------------------------------------------------------------------
  // NOTE: sequential logic uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw_in ^ INVERT};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= STABLE_LO;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      STABLE_LO: if (s)  next_state = CHK_HI;
      CHK_HI: begin
        if (!s)                     next_state = STABLE_LO;
        else if (db_cnt == CNT_LAST) next_state = STABLE_HI;
      end
      STABLE_HI: if (!s) next_state = CHK_LO;
      CHK_LO: begin
        if (s)                      next_state = STABLE_HI;
        else if (db_cnt == CNT_LAST) next_state = STABLE_LO;
      end
      default: next_state = STABLE_LO;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / datapath decode
  // The debounce counter is held at zero outside the CHK states, which is the
  // same as clearing it on entry; it only counts while the candidate level
  // persists and stops at CNT_LAST, where the FSM leaves the CHK state.
  // ---------------------------------------------------------------------------
  always_comb begin
    db_cnt_d = '0;
    abort    = 1'b0;
    unique case (state)
      CHK_HI: begin
        abort = !s;
        if (s && db_cnt != CNT_LAST) db_cnt_d = db_cnt + 1'b1;
      end
      CHK_LO: begin
        abort = s;
        if (!s && db_cnt != CNT_LAST) db_cnt_d = db_cnt + 1'b1;
      end
      default: db_cnt_d = '0;
    endcase
    // The debounced level is registered from the next state so the output
    // flop toggles on the same edge the FSM commits to the new level.
    level_d = (next_state == STABLE_HI) || (next_state == CHK_LO);
  end

  // ---------------------------------------------------------------------------
  // Registered outputs and statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      db_cnt       <= '0;
      level_out    <= 1'b0;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      press_count  <= '0;
      glitch_count <= '0;
    end else begin
      db_cnt     <= db_cnt_d;
      level_out  <= level_d;
      rise_pulse <= level_d & ~level_out;
      fall_pulse <= ~level_d & level_out;

      // press_count follows the registered strobe, so a clear issued in the
      // strobe cycle collides with the increment; the clear wins.
      if (clr_counts) begin
        press_count <= '0;
      end else if (rise_pulse) begin
        press_count <= press_count + 1'b1;
      end

      if (clr_counts) begin
        glitch_count <= '0;
      end else if (abort && glitch_count != {CNT_W{1'b1}}) begin
        glitch_count <= glitch_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_print_in_conditioner.sv
// -----------------------------------------------------------------------------
// tb_print_in_conditioner
//
// Drives a DEBOUNCE_CYCLES=4 / SYNC_STAGES=2 instance plus an INVERT=1
// instance. Each stimulus task pushes the strobes it expects (kind, cycle,
// resulting press count) onto a queue; a negedge monitor pops and compares
// whenever the DUT emits rise_pulse or fall_pulse. Level and counter values
// are also compared inline inside the scenario tasks.
// -----------------------------------------------------------------------------
module tb_print_in_conditioner;

  localparam int LAT = 7;  // SYNC_STAGES + DEBOUNCE_CYCLES + 1

  logic       clk = 1'b0;
  logic       reset_n;
  logic       raw_in;
  logic       raw_inv;
  logic       clr_counts;
  logic       level_out, rise_pulse, fall_pulse;
  logic [7:0] press_count, glitch_count;
  logic       inv_level, inv_rise, inv_fall;
  logic [7:0] inv_press, inv_glitch;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int exp_press = 0;

  typedef struct {
    bit         rise;
    int         at;
    logic [7:0] press;
  } ev_t;

  ev_t        sb[$];
  ev_t        ev;
  bit         press_pending = 1'b0;
  logic [7:0] press_after = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  print_in_conditioner #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .DB_W(4), .CNT_W(8), .INVERT(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .raw_in(raw_in), .clr_counts(clr_counts),
    .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .press_count(press_count), .glitch_count(glitch_count)
  );

  print_in_conditioner #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .DB_W(4), .CNT_W(8), .INVERT(1'b1)
  ) dut_inv (
    .clk(clk), .reset_n(reset_n), .raw_in(raw_inv), .clr_counts(clr_counts),
    .level_out(inv_level), .rise_pulse(inv_rise), .fall_pulse(inv_fall),
    .press_count(inv_press), .glitch_count(inv_glitch)
  );

  // Strobe monitor: every strobe must match the head of the expectation queue
  // in kind and cycle; the press count is checked on the cycle after a rise.
  always @(negedge clk) begin
    if (press_pending) begin
      press_pending = 1'b0;
      vectors++;
      if (press_count !== press_after) begin
        miscompares++;
        $display("FAIL press_after_rise @%0d: got %0d expected %0d", cyc, press_count, press_after);
      end
    end
    if (rise_pulse === 1'b1 || fall_pulse === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe @%0d: rise=%b fall=%b", cyc, rise_pulse, fall_pulse);
      end else begin
        ev = sb.pop_front();
        if (rise_pulse !== ev.rise || fall_pulse !== !ev.rise || cyc != ev.at) begin
          miscompares++;
          $display("FAIL strobe: got rise=%b fall=%b @%0d expected rise=%b @%0d",
                   rise_pulse, fall_pulse, cyc, ev.rise, ev.at);
        end
        if (ev.rise) begin
          press_pending = 1'b1;
          press_after   = ev.press;
        end
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_rise(input int at);
    exp_press = (exp_press + 1) % 256;
    sb.push_back('{rise: 1'b1, at: at, press: 8'(exp_press)});
  endtask

  task automatic push_fall(input int at);
    sb.push_back('{rise: 1'b0, at: at, press: 8'(exp_press)});
  endtask

  // Bring the main DUT back to a settled low level.
  task automatic settle_low();
    int c;
    c = cyc;
    raw_in = 1'b0;
    push_fall(c + LAT);
    wait_until(c + LAT + 3);
    vectors++;
    if (level_out !== 1'b0) begin
      miscompares++;
      $display("FAIL settle_low: level_out got %b expected 0", level_out);
    end
  endtask

  task automatic test_reset();
    int c0;
    reset_n = 1'b0; raw_in = 1'b1; raw_inv = 1'b1; clr_counts = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({level_out, rise_pulse, fall_pulse} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_bits: got %b expected 000", {level_out, rise_pulse, fall_pulse});
    end
    vectors++;
    if (press_count !== 8'd0 || glitch_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_counts: got %0d/%0d expected 0/0", press_count, glitch_count);
    end
    c0 = cyc;
    reset_n = 1'b1;
    push_rise(c0 + LAT);
    wait_until(c0 + LAT - 1);
    vectors++;
    if (level_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_early: level_out got %b expected 0", level_out);
    end
    wait_until(c0 + LAT);
    vectors++;
    if (level_out !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_level: level_out got %b expected 1", level_out);
    end
    wait_until(c0 + LAT + 3);
  endtask

  task automatic test_clean_press();
    int c0;
    settle_low();
    c0 = cyc;
    raw_in = 1'b1;
    push_rise(c0 + LAT);
    wait_until(c0 + LAT - 1);
    vectors++;
    if (level_out !== 1'b0) begin
      miscompares++;
      $display("FAIL press_early: level_out got %b expected 0", level_out);
    end
    wait_until(c0 + LAT);
    vectors++;
    if (level_out !== 1'b1) begin
      miscompares++;
      $display("FAIL press_level: level_out got %b expected 1", level_out);
    end
    wait_until(c0 + 20);
    raw_in = 1'b0;
    push_fall(c0 + 20 + LAT);
    wait_until(c0 + 20 + LAT - 1);
    vectors++;
    if (level_out !== 1'b1) begin
      miscompares++;
      $display("FAIL release_early: level_out got %b expected 1", level_out);
    end
    wait_until(c0 + 20 + LAT);
    vectors++;
    if (level_out !== 1'b0) begin
      miscompares++;
      $display("FAIL release_level: level_out got %b expected 0", level_out);
    end
    wait_until(c0 + 30);
    vectors++;
    if (glitch_count !== 8'd0) begin
      miscompares++;
      $display("FAIL press_glitch: glitch_count got %0d expected 0", glitch_count);
    end
  endtask

  task automatic test_glitch();
    int c;
    c = cyc;
    raw_in = 1'b1;
    wait_until(c + 3);
    raw_in = 1'b0;
    wait_until(c + 12);
    vectors++;
    if (level_out !== 1'b0 || glitch_count !== 8'd1) begin
      miscompares++;
      $display("FAIL glitch_hi: level/glitch got %b/%0d expected 0/1", level_out, glitch_count);
    end
    c = cyc;
    raw_in = 1'b1;
    push_rise(c + LAT);
    wait_until(c + LAT + 3);
    c = cyc;
    raw_in = 1'b0;
    wait_until(c + 2);
    raw_in = 1'b1;
    wait_until(c + 12);
    vectors++;
    if (level_out !== 1'b1 || glitch_count !== 8'd2) begin
      miscompares++;
      $display("FAIL glitch_lo: level/glitch got %b/%0d expected 1/2", level_out, glitch_count);
    end
    settle_low();
  endtask

  task automatic test_wrap_saturate();
    int c;
    clr_counts = 1'b1;
    @(negedge clk);
    clr_counts = 1'b0;
    exp_press  = 0;
    vectors++;
    if (press_count !== 8'd0 || glitch_count !== 8'd0) begin
      miscompares++;
      $display("FAIL clear: counts got %0d/%0d expected 0/0", press_count, glitch_count);
    end
    for (int i = 0; i < 256; i++) begin
      c = cyc;
      raw_in = 1'b1;
      push_rise(c + LAT);
      wait_until(c + 8);
      raw_in = 1'b0;
      push_fall(c + 8 + LAT);
      wait_until(c + 16);
    end
    vectors++;
    if (press_count !== 8'd0) begin
      miscompares++;
      $display("FAIL press_wrap: press_count got %0d expected 0", press_count);
    end
    for (int i = 0; i < 260; i++) begin
      c = cyc;
      raw_in = 1'b1;
      wait_until(c + 2);
      raw_in = 1'b0;
      wait_until(c + 6);
      if (i == 254) begin
        vectors++;
        if (glitch_count !== 8'd255) begin
          miscompares++;
          $display("FAIL glitch_255: glitch_count got %0d expected 255", glitch_count);
        end
      end
    end
    vectors++;
    if (glitch_count !== 8'd255 || level_out !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_sat: glitch/level got %0d/%b expected 255/0", glitch_count, level_out);
    end
  endtask

  task automatic test_clear_collision();
    int c0;
    c0 = cyc;
    raw_in = 1'b1;
    exp_press = -1;  // clear wins over the increment, so 0 is expected after the rise
    push_rise(c0 + LAT);
    wait_until(c0 + LAT);
    clr_counts = 1'b1;
    @(negedge clk);
    clr_counts = 1'b0;
    vectors++;
    if (press_count !== 8'd0 || glitch_count !== 8'd0) begin
      miscompares++;
      $display("FAIL clear_collision: counts got %0d/%0d expected 0/0", press_count, glitch_count);
    end
    wait_until(c0 + 12);
    settle_low();
  endtask

  task automatic test_reset_mid_debounce();
    int c0, c1;
    c0 = cyc;
    raw_in = 1'b1;
    wait_until(c0 + 5);
    reset_n = 1'b0;
    wait_until(c0 + 7);
    vectors++;
    if (level_out !== 1'b0 || rise_pulse !== 1'b0 || press_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_mid: level/rise/press got %b/%b/%0d expected 0/0/0",
               level_out, rise_pulse, press_count);
    end
    c1 = cyc;
    reset_n = 1'b1;
    exp_press = 0;
    push_rise(c1 + LAT);
    wait_until(c1 + LAT + 3);
    vectors++;
    if (level_out !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_rearm: level_out got %b expected 1", level_out);
    end
    settle_low();
  endtask

  task automatic test_invert();
    int c0, c1;
    c0 = cyc;
    raw_inv = 1'b0;
    wait_until(c0 + LAT - 1);
    vectors++;
    if (inv_level !== 1'b0) begin
      miscompares++;
      $display("FAIL inv_early: level got %b expected 0", inv_level);
    end
    wait_until(c0 + LAT);
    vectors++;
    if (inv_level !== 1'b1 || inv_rise !== 1'b1) begin
      miscompares++;
      $display("FAIL inv_rise: level/rise got %b/%b expected 1/1", inv_level, inv_rise);
    end
    wait_until(c0 + 10);
    c1 = cyc;
    raw_inv = 1'b1;
    wait_until(c1 + LAT - 1);
    vectors++;
    if (inv_level !== 1'b1) begin
      miscompares++;
      $display("FAIL inv_hold: level got %b expected 1", inv_level);
    end
    wait_until(c1 + LAT);
    vectors++;
    if (inv_level !== 1'b0 || inv_fall !== 1'b1) begin
      miscompares++;
      $display("FAIL inv_fall: level/fall got %b/%b expected 0/1", inv_level, inv_fall);
    end
    wait_until(c1 + LAT + 2);
    vectors++;
    if (inv_press !== 8'd1 || inv_glitch !== 8'd0) begin
      miscompares++;
      $display("FAIL inv_counts: press/glitch got %0d/%0d expected 1/0", inv_press, inv_glitch);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_wrap_saturate();
    test_clear_collision();
    test_reset_mid_debounce();
    test_invert();
    repeat (3) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL missing_strobes: %0d expected strobes never seen", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
